// File: rtl/write_data_uart_tx_pkg.sv
// Shared definitions for the WriteData UART transmitter: FSM encoding,
// line levels, byte width and the parity helper.
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit per byte).
package uart_tx_pkg;

  localparam int DATA_BITS = 8;

  localparam logic TX_IDLE  = 1'b1;
  localparam logic TX_START = 1'b0;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;
`endif

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data_byte);
    return ^data_byte;
  endfunction

endpackage

// File: rtl/write_data_uart_tx_baud_tick_gen.sv
// Baud-rate counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
// wraps; Tick is a registered one-cycle pulse aligned with the terminal
// count. Clear holds the count at zero so a new bit period starts cleanly.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  // Advance the bit-period counter; raise Tick on the edge entering terminal count.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (Clear) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= (cnt_r == LAST_CNT) ? '0 : cnt_r + CNT_W'(1);
      tick_r <= (cnt_r == PRE_CNT);
    end
  end

  assign Tick = tick_r;

endmodule

// File: rtl/write_data_uart_tx.sv
// WriteData UART transmitter: accepts one word per valid/ready handshake and
// sends it as NUM_BYTES framed bytes, most-significant byte first, each byte
// LSB first (8N1). With UART_PARITY_EN defined an even-parity bit is sent
// between the data bits and the stop bit (8E1).
module write_data_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_BYTES    = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [8*NUM_BYTES-1:0] DataIn,
  input  logic                   DataValid,
  output logic                   Ready,
  output logic                   Tx,
  output logic                   Busy
);

  localparam int WORD_W = 8 * NUM_BYTES;
  localparam int BYTE_W = $clog2(NUM_BYTES + 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

  state_e                 state_r;
  logic [WORD_W-1:0]      shift_r;
  logic [2:0]             bit_cnt_r;
  logic [BYTE_W-1:0]      byte_cnt_r;
  logic                   tx_r;
  logic                   ready_r;
  logic                   busy_r;

  logic                   clear_s;
  logic                   tick_s;
  logic                   accept_s;
  logic [DATA_BITS-1:0]   cur_byte_s;

  // Baud counter is held at zero while idle so the start bit gets a full period.
  assign clear_s    = (state_r == IDLE);
  assign accept_s   = DataValid & ready_r;
  assign cur_byte_s = shift_r[WORD_W-1 -: DATA_BITS];

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (clear_s),
    .Tick  (tick_s)
  );

  // Frame sequencer: handshake, start/data/(parity)/stop bits, byte stepping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= '0;
      tx_r       <= TX_IDLE;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            shift_r    <= DataIn;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= '0;
            tx_r       <= TX_START;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= START;
          end else begin
            tx_r    <= TX_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        START: begin
          if (tick_s) begin
            bit_cnt_r <= 3'd0;
            tx_r      <= cur_byte_s[0];
            state_r   <= DATA;
          end
        end
        DATA: begin
          if (tick_s) begin
            if (bit_cnt_r == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_r    <= even_parity(cur_byte_s);
              state_r <= PARITY;
`else
              tx_r    <= TX_IDLE;
              state_r <= STOP;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              tx_r      <= cur_byte_s[bit_cnt_r + 3'd1];
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (tick_s) begin
            tx_r    <= TX_IDLE;
            state_r <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick_s) begin
            if (byte_cnt_r == LAST_BYTE) begin
              tx_r    <= TX_IDLE;
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              byte_cnt_r <= byte_cnt_r + BYTE_W'(1);
              shift_r    <= shift_r << 8;
              tx_r       <= TX_START;
              state_r    <= START;
            end
          end
        end
        default: begin
          tx_r    <= TX_IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign Tx    = tx_r;
  assign Ready = ready_r;
  assign Busy  = busy_r;

endmodule

// File: tb/tb_write_data_uart_tx.sv
// Directed bench for write_data_uart_tx with CLKS_PER_BIT=4. Expected bytes
// are pushed to a scoreboard queue when a word is offered and popped as each
// UART frame is decoded from Tx, cycle by cycle.
module tb_write_data_uart_tx;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int  FRAME_BITS = 11;
  localparam bit  HAS_PAR    = 1'b1;
`else
  localparam int  FRAME_BITS = 10;
  localparam bit  HAS_PAR    = 1'b0;
`endif
  localparam int WORD_CYCLES = 4 * FRAME_BITS * CPB;

  logic        Clk;
  logic        Reset;
  logic [31:0] DataIn;
  logic        DataValid;
  logic        Ready;
  logic        Tx;
  logic        Busy;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb[$];

  write_data_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .NUM_BYTES    (4)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .DataIn    (DataIn),
    .DataValid (DataValid),
    .Ready     (Ready),
    .Tx        (Tx),
    .Busy      (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, {31'd0, Tx}, 32'd1);
    chk({tag, "_ready"}, {31'd0, Ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
  endtask

  // Wait (bounded) for Ready, offer one word for one cycle, then scramble DataIn.
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    while (Ready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    chk("ready_wait", {31'd0, Ready}, 32'd1);
    DataIn    = w;
    DataValid = 1'b1;
    for (int b = 3; b >= 0; b--) sb.push_back(w[8*b +: 8]);
    step();
    DataValid = 1'b0;
    DataIn    = 32'h0;
  endtask

  // Decode four frames from Tx starting on the first cycle after acceptance.
  // poke_at != 0 offers DEADBEEF for one cycle at that cycle of the word.
  task automatic recv_word(input int poke_at);
    logic [7:0] exp_b;
    logic [7:0] got_b;
    int cyc;
    cyc = 0;
    for (int by = 0; by < 4; by++) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
        exp_b = 8'h00;
      end else begin
        exp_b = sb.pop_front();
      end
      got_b = 8'h00;
      for (int k = 0; k < FRAME_BITS; k++) begin
        for (int i = 0; i < CPB; i++) begin
          cyc++;
          if (poke_at != 0 && cyc == poke_at) begin
            DataIn    = 32'hDEADBEEF;
            DataValid = 1'b1;
          end else if (poke_at != 0 && cyc == poke_at + 1) begin
            DataValid = 1'b0;
            DataIn    = 32'h0;
          end
          if (k == 0) begin
            chk("start_bit", {31'd0, Tx}, 32'd0);
            if (i == 0) chk("ready_low", {31'd0, Ready}, 32'd0);
          end else if (k <= 8) begin
            if (i == CPB / 2) got_b[k-1] = Tx;
          end else if (HAS_PAR && k == 9) begin
            if (i == CPB / 2) chk("parity_bit", {31'd0, Tx}, {31'd0, ^exp_b});
          end else begin
            chk("stop_bit", {31'd0, Tx}, 32'd1);
          end
          if (cyc == WORD_CYCLES) chk("ready_last_stop", {31'd0, Ready}, 32'd0);
          step();
        end
      end
      chk("byte", {24'd0, got_b}, {24'd0, exp_b});
    end
    chk("ready_after_word", {31'd0, Ready}, 32'd1);
    chk("busy_after_word", {31'd0, Busy}, 32'd0);
    chk("tx_after_word", {31'd0, Tx}, 32'd1);
  endtask

  initial begin
    Reset     = 1'b1;
    DataIn    = 32'h0;
    DataValid = 1'b0;

    // Power-on reset and quiet idle.
    step();
    step();
    chk_idle("por");
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("idle");
    end

    // Reset pulsed for two cycles while idle.
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_idle("idle_rst");
    end
    Reset = 1'b0;
    step();
    chk_idle("idle_rst_release");

    // Single word, MSB byte first.
    send_word(32'hA5C3_0F81);
    recv_word(0);

    // DataValid pulsed while busy must be ignored.
    send_word(32'h3C96_E187);
    recv_word(30);
    for (int i = 0; i < 12; i++) begin
      step();
      chk_idle("after_ignored");
    end

    // Back-to-back words with DataValid held high.
    DataIn    = 32'h0000_0001;
    DataValid = 1'b1;
    for (int b = 3; b >= 0; b--) sb.push_back(DataIn[8*b +: 8]);
    step();
    DataIn = 32'hFFFF_FFFF;
    for (int b = 3; b >= 0; b--) sb.push_back(DataIn[8*b +: 8]);
    recv_word(0);
    step();
    DataValid = 1'b0;
    DataIn    = 32'h0;
    recv_word(0);

    // Reset in the middle of a word, then a clean word.
    send_word(32'hCAFE_F00D);
    for (int i = 1; i < 50; i++) step();
    Reset = 1'b1;
    #1;
    chk_idle("midframe_rst");
    chk("midframe_state", 32'(dut.state_r), 32'd0);
    sb.delete();
    step();
    step();
    Reset = 1'b0;
    step();
    chk_idle("midframe_release");
    send_word(32'h1234_5678);
    recv_word(0);

`ifdef UART_PARITY_EN
    // Parity: 07 has three ones (parity 1), 03 has two (parity 0).
    send_word(32'h0703_0703);
    recv_word(0);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
